kb_text_ctrl: RTL and testbench
===============================

// Module: kb_text_ctrl
// PURPOSE
//  Sequences the character buffer that sits between the PS/2 receiver (kb) and the VGA font renderer (vga).
//  Consumes raw PS/2 set-2 scan codes and decodes make/break/extended prefixes and shift state.
//  Writes ASCII cells into the dual-port char RAM, whose write port it owns; vga owns the read port.
//  Maintains the text cursor and clears the screen after reset.
// PARAMETERS
//  COLS    80  text columns per row
//  ROWS    30  text rows
//  ADDR_W  12  char RAM address width; must satisfy 2**ADDR_W >= COLS*ROWS
// PORTS
//  mclk        in   1       system clock; all state on rising edge
//  reset       in   1       asynchronous, active-low reset
//  scan_valid  in   1       1-cycle strobe: scan_code holds a complete byte
//  scan_code   in   8       PS/2 set-2 byte from kb
//  wr_en       out  1       char RAM write strobe, 1 cycle
//  wr_addr     out  ADDR_W  row*COLS+col of written cell
//  wr_data     out  8       ASCII byte written
//  cursor_col  out  7       current column, 0..COLS-1
//  cursor_row  out  5       current row, 0..ROWS-1
//  busy        out  1       high while the clear sweep runs; input ignored
//  shift_on    out  1       either shift key currently held
// BEHAVIOUR
//  Reset (async assert): all outputs 0, cursor (0,0), shift_on=0, state=CLEAR.
//  CLEAR: busy=1; writes 0x20 to addr 0..COLS*ROWS-1, one cell per cycle.
//   Then enters IDLE. scan_valid during CLEAR is dropped, not queued.
//  FSM states: CLEAR, IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0), WRITE.
//  IDLE: F0 -> BRK; E0 -> EXT.
//   12/59 -> shift_on=1.
//   Other codes go through the scan_to_ascii lookup:
//    nonzero result -> WRITE.
//    Enter (5A) -> col=0, row+1.
//    Backspace (66) -> WRITE with 0x20 at the previous cell.
//    Zero result -> ignored.
//  BRK: next byte consumed; if 12/59 then shift_on=0. Return to IDLE.
//  EXT: 6B/74/75/72 move the cursor left/right/up/down by one cell, no write.
//   F0 -> EXT_BRK. Any other byte -> IDLE.
//  EXT_BRK: next byte discarded -> IDLE.
//  Only a byte arriving with scan_valid advances BRK/EXT/EXT_BRK; the FSM waits in those states indefinitely.
//  Latency: scan_valid at cycle N -> wr_en at N+1, with wr_addr/wr_data registered, -> IDLE at N+2.
//   Cursor updates at N+1; write uses the pre-advance position except for backspace.
//  Printable write: col+1; col==COLS-1 -> col=0, row+1.
//   Row wraps ROWS-1 -> 0. No scrolling.
//  Backspace at (0,0): cursor stays, writes 0x20 at addr 0.
//   At col 0, row r>0: moves to (COLS-1, r-1).
//  Arrows saturate at borders; no wrap.
//  scan_valid in WRITE state: byte dropped (kb rate << mclk, so never hit in practice).
//  Address: computed as row*COLS+col, combinational from registered cursor, then registered.
//   No overflow for the parameter defaults.
//  Reset asserted mid-CLEAR or mid-sequence: restart CLEAR from addr 0; the prefix state is lost.
// STRUCTURE
//  Shared package kb_vga_pkg:
//   - scan code constants: SC_BRK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59, SC_ENTER=5A, SC_BKSP=66, arrow codes
//   - ASCII_SPACE
//   - state enum encoding
//  Sub-module scan_to_ascii: combinational map (code, shift) -> ASCII.
//   0 for unmapped codes; covers letters, digits, space, basic punctuation.
//  Top file contains the FSM, cursor counters and clear counter.
// TESTING
//  1 Reset release -> busy=1 for exactly 2400 cycles; wr_en every cycle, addr 0..2399, data 0x20; then busy=0, cursor (0,0).
//  2 After clear, send 1C (a) -> next cycle wr_en, addr 0, data 0x61; cursor (1,0). Then send F0,1C -> no wr_en.
//  3 Send 12, 1C, F0,12, 1C -> writes 0x41 at addr 0, then 0x61 at addr 1; shift_on 1 then 0.
//  4 Cursor at (79,0), send 32 (b) -> write addr 79; cursor (0,1). At (79,29) with a printable key -> cursor wraps to (0,0).
//  5 Cursor (0,1), send 66 -> cursor (79,0), wr_addr 79, data 0x20. Send E0,6B at col 0 -> cursor unchanged, no write.
//  6 Assert reset during CLEAR at addr 1000 -> outputs 0 immediately. After release, clear restarts at addr 0.

Source files
------------

// File: rtl/kb_vga_pkg.sv
// Shared definitions for the keyboard-to-text path: PS/2 set-2 scan code
// constants, the ASCII fill character and the controller state encoding.
package kb_vga_pkg;

    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    // Extended (E0-prefixed) arrow codes
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_DOWN   = 8'h72;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StBrk,
        StExt,
        StExtBrk,
        StWrite
    } state_e;

endpackage

// File: rtl/kb_text_ctrl_if.sv
// Bus between kb (scan byte strobe) and the char RAM write port.
//   scan_valid/scan_code : byte strobe from the PS/2 receiver
//   wr_en/wr_addr/wr_data: char RAM write port
// master = keyboard/RAM side, slave = kb_text_ctrl.
interface kb_text_ctrl_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              scan_valid;
    logic [7:0]        scan_code;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        output scan_valid, scan_code,
        input  wr_en, wr_addr, wr_data
    );

    modport slave (
        input  scan_valid, scan_code,
        output wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/scan_to_ascii.sv
// Combinational PS/2 set-2 scan code to ASCII map.
//   code_i  : scan code byte
//   shift_i : shift held
//   ascii_o : ASCII character, 0 for unmapped codes
// Covers letters, digits, space and basic punctuation.
module scan_to_ascii (
    input  logic [7:0] code_i,
    input  logic       shift_i,
    output logic [7:0] ascii_o
);
    logic [7:0] lo, hi;

    always_comb begin
        lo = 8'h00;
        hi = 8'h00;
        case (code_i)
            8'h1C: begin lo = "a"; hi = "A"; end
            8'h32: begin lo = "b"; hi = "B"; end
            8'h21: begin lo = "c"; hi = "C"; end
            8'h23: begin lo = "d"; hi = "D"; end
            8'h24: begin lo = "e"; hi = "E"; end
            8'h2B: begin lo = "f"; hi = "F"; end
            8'h34: begin lo = "g"; hi = "G"; end
            8'h33: begin lo = "h"; hi = "H"; end
            8'h43: begin lo = "i"; hi = "I"; end
            8'h3B: begin lo = "j"; hi = "J"; end
            8'h42: begin lo = "k"; hi = "K"; end
            8'h4B: begin lo = "l"; hi = "L"; end
            8'h3A: begin lo = "m"; hi = "M"; end
            8'h31: begin lo = "n"; hi = "N"; end
            8'h44: begin lo = "o"; hi = "O"; end
            8'h4D: begin lo = "p"; hi = "P"; end
            8'h15: begin lo = "q"; hi = "Q"; end
            8'h2D: begin lo = "r"; hi = "R"; end
            8'h1B: begin lo = "s"; hi = "S"; end
            8'h2C: begin lo = "t"; hi = "T"; end
            8'h3C: begin lo = "u"; hi = "U"; end
            8'h2A: begin lo = "v"; hi = "V"; end
            8'h1D: begin lo = "w"; hi = "W"; end
            8'h22: begin lo = "x"; hi = "X"; end
            8'h35: begin lo = "y"; hi = "Y"; end
            8'h1A: begin lo = "z"; hi = "Z"; end
            8'h45: begin lo = "0"; hi = ")"; end
            8'h16: begin lo = "1"; hi = "!"; end
            8'h1E: begin lo = "2"; hi = "@"; end
            8'h26: begin lo = "3"; hi = "#"; end
            8'h25: begin lo = "4"; hi = "$"; end
            8'h2E: begin lo = "5"; hi = "%"; end
            8'h36: begin lo = "6"; hi = "^"; end
            8'h3D: begin lo = "7"; hi = "&"; end
            8'h3E: begin lo = "8"; hi = "*"; end
            8'h46: begin lo = "9"; hi = "("; end
            8'h29: begin lo = " "; hi = " "; end
            8'h41: begin lo = ","; hi = "<"; end
            8'h49: begin lo = "."; hi = ">"; end
            8'h4A: begin lo = "/"; hi = "?"; end
            8'h4E: begin lo = "-"; hi = "_"; end
            8'h55: begin lo = "="; hi = "+"; end
            8'h4C: begin lo = ";"; hi = ":"; end
            8'h52: begin lo = "'"; hi = "\""; end
            default: begin lo = 8'h00; hi = 8'h00; end
        endcase
        ascii_o = shift_i ? hi : lo;
    end
endmodule

// File: rtl/kb_text_ctrl.sv
// Text-buffer sequencer between the PS/2 receiver and the char RAM.
//   mclk, reset            : clock, async active-low reset
//   bus (slave)            : scan byte strobe in, char RAM write port out
//   cursor_col/cursor_row  : current text cursor
//   busy                   : clear sweep in progress, scan input ignored
//   shift_on               : a shift key is held
// Clears the screen after reset, then decodes make/break/extended codes,
// writes ASCII cells and moves the cursor.
module kb_text_ctrl
    import kb_vga_pkg::*;
#(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned ADDR_W = 12  // 2**ADDR_W >= COLS*ROWS
) (
    input  logic           mclk,
    input  logic           reset,
    kb_text_ctrl_if.slave  bus,
    output logic [6:0]     cursor_col,
    output logic [4:0]     cursor_row,
    output logic           busy,
    output logic           shift_on
);
    localparam logic [6:0]        ColMax  = 7'(COLS - 1);
    localparam logic [4:0]        RowMax  = 5'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ClrLast = ADDR_W'(COLS * ROWS - 1);

    state_e            state_q, state_d;
    logic [6:0]        col_q, col_d;
    logic [4:0]        row_q, row_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              shift_q, shift_d;

    logic [7:0]        ascii;
    logic [6:0]        bk_col, adv_col;
    logic [4:0]        bk_row, adv_row, nl_row;
    logic [ADDR_W-1:0] cur_addr, bk_addr;

    scan_to_ascii u_map (
        .code_i  (bus.scan_code),
        .shift_i (shift_q),
        .ascii_o (ascii)
    );

    // Cursor arithmetic: next line, advance after a write, backspace target
    always_comb begin
        nl_row  = (row_q == RowMax) ? 5'd0 : row_q + 5'd1;
        adv_col = (col_q == ColMax) ? 7'd0 : col_q + 7'd1;
        adv_row = (col_q == ColMax) ? nl_row : row_q;
        bk_col  = col_q;
        bk_row  = row_q;
        if (col_q != 7'd0) begin
            bk_col = col_q - 7'd1;
        end else if (row_q != 5'd0) begin
            bk_col = ColMax;
            bk_row = row_q - 5'd1;
        end
        cur_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
        bk_addr  = ADDR_W'(bk_row) * ADDR_W'(COLS) + ADDR_W'(bk_col);
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        clr_d     = clr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = 1'b0;
        shift_d   = shift_q;
        unique case (state_q)
            StClear: begin
                busy_d    = 1'b1;
                wr_en_d   = 1'b1;
                wr_addr_d = clr_q;
                wr_data_d = ASCII_SPACE;
                if (clr_q == ClrLast) begin
                    clr_d   = '0;
                    state_d = StIdle;
                end else begin
                    clr_d = clr_q + 1'b1;
                end
            end
            StIdle: begin
                if (bus.scan_valid) begin
                    case (bus.scan_code)
                        SC_BRK:    state_d = StBrk;
                        SC_EXT:    state_d = StExt;
                        SC_LSHIFT,
                        SC_RSHIFT: shift_d = 1'b1;
                        SC_ENTER: begin
                            col_d = 7'd0;
                            row_d = nl_row;
                        end
                        SC_BKSP: begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = bk_addr;
                            wr_data_d = ASCII_SPACE;
                            col_d     = bk_col;
                            row_d     = bk_row;
                            state_d   = StWrite;
                        end
                        default: begin
                            if (ascii != 8'h00) begin
                                wr_en_d   = 1'b1;
                                wr_addr_d = cur_addr;
                                wr_data_d = ascii;
                                col_d     = adv_col;
                                row_d     = adv_row;
                                state_d   = StWrite;
                            end
                        end
                    endcase
                end
            end
            StBrk: begin
                if (bus.scan_valid) begin
                    if (bus.scan_code == SC_LSHIFT || bus.scan_code == SC_RSHIFT) begin
                        shift_d = 1'b0;
                    end
                    state_d = StIdle;
                end
            end
            StExt: begin
                if (bus.scan_valid) begin
                    state_d = StIdle;
                    case (bus.scan_code)
                        SC_LEFT:  if (col_q != 7'd0)  col_d = col_q - 7'd1;
                        SC_RIGHT: if (col_q != ColMax) col_d = col_q + 7'd1;
                        SC_UP:    if (row_q != 5'd0)  row_d = row_q - 5'd1;
                        SC_DOWN:  if (row_q != RowMax) row_d = row_q + 5'd1;
                        SC_BRK:   state_d = StExtBrk;
                        default:  state_d = StIdle;
                    endcase
                end
            end
            StExtBrk: begin
                if (bus.scan_valid) begin
                    state_d = StIdle;
                end
            end
            StWrite: state_d = StIdle;  // bytes arriving here are dropped
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q   <= StClear;
            col_q     <= '0;
            row_q     <= '0;
            clr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            shift_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            clr_q     <= clr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            shift_q   <= shift_d;
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign cursor_col  = col_q;
    assign cursor_row  = row_q;
    assign busy        = busy_q;
    assign shift_on    = shift_q;
endmodule

// File: tb/tb_kb_text_ctrl.sv
// Scoreboard bench for kb_text_ctrl: expected char RAM writes are queued
// by the stimulus; a monitor pops and compares each observed write.
module tb_kb_text_ctrl;
    logic       mclk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;
    logic       shift_on;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;
    wr_t sb[$];

    kb_text_ctrl_if #(.ADDR_W(12)) bus ();

    kb_text_ctrl #(.COLS(80), .ROWS(30), .ADDR_W(12)) dut (
        .mclk       (mclk),
        .reset      (reset),
        .bus        (bus),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy),
        .shift_on   (shift_on)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard
    always @(negedge mclk) begin
        if (reset && bus.wr_en === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected none",
                         bus.wr_addr, bus.wr_data);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (bus.wr_addr !== e.addr || bus.wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                             bus.wr_addr, bus.wr_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic expect_wr(input int a, input logic [7:0] d);
        wr_t e;
        e.addr = 12'(a);
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_clear();
        for (int i = 0; i < 2400; i++) expect_wr(i, 8'h20);
    endtask

    task automatic send(input logic [7:0] c);
        @(posedge mclk);
        #1 bus.scan_valid = 1'b1;
        bus.scan_code = c;
        @(posedge mclk);
        #1 bus.scan_valid = 1'b0;
        repeat (2) @(posedge mclk);
        #1;
    endtask

    task automatic arrow(input logic [7:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            send(8'hE0);
            send(c);
        end
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        check({name, "_col"}, 32'(cursor_col), 32'(col));
        check({name, "_row"}, 32'(cursor_row), 32'(row));
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge mclk);
            if (!busy) break;
        end
        check({name, "_busy_timeout"}, 32'(i < 3000), 32'd1);
    endtask

    initial begin
        int cnt;
        bit hit;
        bus.scan_valid = 1'b0;
        bus.scan_code  = 8'h00;

        // 1: reset state and clear sweep
        push_clear();
        repeat (3) @(negedge mclk);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check_cursor("rst", 0, 0);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge mclk);
            if (busy) cnt++;
            else if (cnt > 0) break;
        end
        check("clear_busy_cycles", 32'(cnt), 32'd2400);
        check("clear_sb_drained", 32'(sb.size()), 32'd0);
        check_cursor("clear", 0, 0);

        // 2: plain key, then its break code writes nothing
        expect_wr(0, 8'h61);
        send(8'h1C);
        check_cursor("key_a", 1, 0);
        send(8'hF0);
        send(8'h1C);
        check_cursor("brk_a", 1, 0);

        // 3: backspace to origin, then shifted and unshifted 'a'
        expect_wr(0, 8'h20);
        send(8'h66);
        check_cursor("bksp0", 0, 0);
        send(8'h12);
        check("shift_on", 32'(shift_on), 32'd1);
        expect_wr(0, 8'h41);
        send(8'h1C);
        send(8'hF0);
        send(8'h12);
        check("shift_off", 32'(shift_on), 32'd0);
        expect_wr(1, 8'h61);
        send(8'h1C);
        check_cursor("after_Aa", 2, 0);

        // Unmapped code and extended sequences that must not move/write
        send(8'h05);
        send(8'hE0);
        send(8'h11);
        send(8'hE0);
        send(8'hF0);
        send(8'h74);
        check_cursor("noop_codes", 2, 0);

        // 4: end-of-row wrap
        arrow(8'h74, 77);
        check_cursor("at_79_0", 79, 0);
        arrow(8'h74, 1);
        check_cursor("right_sat", 79, 0);
        arrow(8'h75, 1);
        check_cursor("up_sat", 79, 0);
        expect_wr(79, 8'h62);
        send(8'h32);
        check_cursor("row_wrap", 0, 1);

        // 5: backspace across a row, enter, left saturation
        expect_wr(79, 8'h20);
        send(8'h66);
        check_cursor("bksp_row", 79, 0);
        send(8'h5A);
        check_cursor("enter", 0, 1);
        arrow(8'h6B, 1);
        check_cursor("left_sat", 0, 1);

        // Screen wrap from the last cell
        arrow(8'h74, 79);
        arrow(8'h72, 28);
        check_cursor("at_79_29", 79, 29);
        arrow(8'h72, 1);
        check_cursor("down_sat", 79, 29);
        expect_wr(2399, 8'h61);
        send(8'h1C);
        check_cursor("screen_wrap", 0, 0);
        expect_wr(0, 8'h20);
        send(8'h66);
        check_cursor("bksp_origin", 0, 0);

        // 6: reset mid-clear restarts the sweep; input during clear is dropped
        send(8'h12);
        reset = 1'b0;
        sb.delete();
        push_clear();
        #20 reset = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge mclk);
            if (bus.wr_en && bus.wr_addr == 12'd1000) begin
                hit = 1'b1;
                break;
            end
        end
        check("reach_addr_1000", 32'(hit), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("midrst_wr_en", 32'(bus.wr_en), 32'd0);
        check("midrst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_shift", 32'(shift_on), 32'd0);
        sb.delete();
        push_clear();
        @(negedge mclk);
        reset = 1'b1;
        repeat (5) @(posedge mclk);
        #1 bus.scan_valid = 1'b1;
        bus.scan_code = 8'h1C;
        @(posedge mclk);
        #1 bus.scan_valid = 1'b0;
        wait_idle("reclear");
        repeat (4) @(negedge mclk);
        check("reclear_sb_drained", 32'(sb.size()), 32'd0);
        check_cursor("reclear", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
